cp0_timer_ctrl: RTL and testbench

Parametrised, fully clocked MIPS32 coprocessor 0 for the single-issue core. Holds Count, Compare, Status, Cause and EPC. Generates a Count/Compare timer interrupt. Arbitrates synchronous exceptions, ERET and masked interrupts into a single PC-redirect request. Sits beside the MEM stage: it takes mfc0/mtc0, exception and ERET requests from that stage and drives the redirect into fetch.

---
 rtl/cp0_pkg.sv | 37 +++
 rtl/cp0_timer.sv | 68 ++++++
 rtl/cp0_timer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cp0_timer_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause bit positions,
// ExcCode values, writable-bit masks and the redirect-source encoding.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;
  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [31:0] STATUS_WR_MASK = 32'h0040_FF03;
  localparam logic [31:0] STATUS_RESET   = 32'h0040_0000;
  localparam logic [31:0] CAUSE_WR_MASK  = 32'h0000_0300;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_EXC  = 2'd1,
    RD_INT  = 2'd2,
    RD_ERET = 2'd3
  } redirect_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky
// timer-interrupt flag TI.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic [3:0]  r_presc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;
  logic [31:0] w_count_inc;

  assign w_tick      = (r_presc == 4'(COUNT_DIV - 1));
  assign w_count_inc = r_count + 32'd1;

  // Prescaler and Count; an mtc0 to Count beats the increment and restarts the prescaler
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= 4'd0;
      r_count <= 32'd0;
    end else if (i_count_we) begin
      r_presc <= 4'd0;
      r_count <= i_wdata;
    end else if (w_tick) begin
      r_presc <= 4'd0;
      r_count <= w_count_inc;
    end else begin
      r_presc <= r_presc + 4'd1;
    end
  end

  // Compare register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_compare <= 32'hFFFF_FFFF;
    end else if (i_compare_we) begin
      r_compare <= i_wdata;
    end
  end

  // TI is raised only by an increment landing on Compare and cleared only by writing Compare
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ti <= 1'b0;
    end else if (i_compare_we) begin
      r_ti <= 1'b0;
    end else if (!i_count_we && w_tick && (w_count_inc == r_compare)) begin
      r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_timer_ctrl.sv
// MIPS32 CP0 slice: Status/Cause/EPC, timer instance, exception/interrupt/ERET
// arbitration into one PC redirect, and the mfc0 read mux.
module cp0_timer_ctrl
  import cp0_pkg::*;
#(
  parameter int          N_HW_INT   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [4:0]          i_rd_addr,
  output logic [31:0]         o_rd_data,
  input  logic                i_wr_en,
  input  logic [4:0]          i_wr_addr,
  input  logic [31:0]         i_wr_data,
  input  logic                i_exc_valid,
  input  logic [4:0]          i_exc_code,
  input  logic [31:0]         i_exc_pc,
  input  logic                i_exc_bd,
  input  logic                i_eret,
  input  logic [31:0]         i_int_pc,
  input  logic [N_HW_INT-1:0] i_hw_int,
  output logic                o_redirect_valid,
  output logic [31:0]         o_redirect_pc,
  output logic                o_int_taken,
  output logic                o_timer_int
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_hw_pad;
  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_wr_ok;
  logic        w_entry;
  redirect_e   w_sel;

  // Zero-extend the external lines onto the six hardware IP slots
  always_comb begin
    w_hw_pad = 6'd0;
    w_hw_pad[N_HW_INT-1:0] = i_hw_int;
  end

  // TI feeds IP7 directly so the interrupt can be taken the cycle after TI rises
  assign w_ip      = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_int_req = r_status[ST_IE] & ~r_status[ST_EXL] & (|(w_ip & r_status[ST_IM_LO +: 8]));

  // Priority: rst > exception > interrupt > eret; mtc0 only when nothing redirects
  always_comb begin
    w_sel = RD_NONE;
    if (i_rst) begin
      w_sel = RD_NONE;
    end else if (i_exc_valid) begin
      w_sel = RD_EXC;
    end else if (w_int_req) begin
      w_sel = RD_INT;
    end else if (i_eret) begin
      w_sel = RD_ERET;
    end else begin
      w_sel = RD_NONE;
    end
  end

  assign w_wr_ok = i_wr_en & (w_sel == RD_NONE) & ~i_rst;
  assign w_entry = (w_sel == RD_EXC) | (w_sel == RD_INT);

  // Redirect outputs decoded from the winning source
  always_comb begin
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'd0;
    o_int_taken      = 1'b0;
    case (w_sel)
      RD_EXC: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = EXC_VECTOR;
      end
      RD_INT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = EXC_VECTOR;
        o_int_taken      = 1'b1;
      end
      RD_ERET: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_epc;
      end
      default: begin
        o_redirect_valid = 1'b0;
        o_redirect_pc    = 32'd0;
        o_int_taken      = 1'b0;
      end
    endcase
  end

  // Status: EXL set on entry, cleared by ERET, otherwise mtc0 of writable bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_status <= STATUS_RESET;
    end else if (w_entry) begin
      r_status[ST_EXL] <= 1'b1;
    end else if (w_sel == RD_ERET) begin
      r_status[ST_EXL] <= 1'b0;
    end else if (w_wr_ok && (i_wr_addr == REG_STATUS)) begin
      r_status <= i_wr_data & STATUS_WR_MASK;
    end
  end

  // EPC/BD are only captured from the outermost level (EXL = 0); ExcCode always updates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc      <= EXC_VECTOR;
      r_bd       <= 1'b0;
      r_exc_code <= EXC_INT;
    end else if (w_entry) begin
      if (!r_status[ST_EXL]) begin
        if (w_sel == RD_EXC) begin
          r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
          r_bd  <= i_exc_bd;
        end else begin
          r_epc <= i_int_pc;
          r_bd  <= 1'b0;
        end
      end
      r_exc_code <= (w_sel == RD_EXC) ? i_exc_code : EXC_INT;
    end else if (w_wr_ok && (i_wr_addr == REG_EPC)) begin
      r_epc <= i_wr_data;
    end
  end

  // Cause.IP: hardware lines sampled every cycle, software bits via mtc0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ip_hw <= 6'd0;
      r_ip_sw <= 2'd0;
    end else begin
      r_ip_hw <= w_hw_pad;
      if (w_wr_ok && (i_wr_addr == REG_CAUSE)) begin
        r_ip_sw <= i_wr_data[CA_IP_LO +: 2];
      end
    end
  end

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_count_we  (w_wr_ok && (i_wr_addr == REG_COUNT)),
    .i_compare_we(w_wr_ok && (i_wr_addr == REG_COMPARE)),
    .i_wdata     (i_wr_data),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_ti        (w_ti)
  );

  // mfc0 read mux; unimplemented numbers read 0
  always_comb begin
    o_rd_data = 32'd0;
    case (i_rd_addr)
      REG_COUNT:   o_rd_data = w_count;
      REG_COMPARE: o_rd_data = w_compare;
      REG_STATUS:  o_rd_data = r_status;
      REG_CAUSE:   o_rd_data = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'd0};
      REG_EPC:     o_rd_data = r_epc;
      default:     o_rd_data = 32'd0;
    endcase
  end

  assign o_timer_int = w_ti;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Self-checking bench for cp0_timer_ctrl: reset table plus directed timer,
// exception, ERET, interrupt and Count-write sequences through a scoreboard.
module tb_cp0_timer_ctrl;
  import cp0_pkg::*;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] int_pc;
  logic [5:0]  hw_int;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_taken;
  logic        timer_int;

  cp0_timer_ctrl #(
    .N_HW_INT  (6),
    .EXC_VECTOR(VEC),
    .COUNT_DIV (2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rd_addr       (rd_addr),
    .o_rd_data       (rd_data),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_exc_valid     (exc_valid),
    .i_exc_code      (exc_code),
    .i_exc_pc        (exc_pc),
    .i_exc_bd        (exc_bd),
    .i_eret          (eret),
    .i_int_pc        (int_pc),
    .i_hw_int        (hw_int),
    .o_redirect_valid(redirect_valid),
    .o_redirect_pc   (redirect_pc),
    .o_int_taken     (int_taken),
    .o_timer_int     (timer_int)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       nm;
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t rv[6];
  int   n_chk;
  int   n_err;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0:       return rd_data;
      1:       return {31'd0, redirect_valid};
      2:       return redirect_pc;
      3:       return {31'd0, int_taken};
      4:       return {31'd0, timer_int};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(string nm, int sel, logic [31:0] e);
    exp_t x;
    x.nm  = nm;
    x.sel = sel;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_chk++;
      if (actual(x.sel) !== x.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", x.nm, actual(x.sel), x.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(string nm, logic [4:0] a, logic [31:0] e);
    rd_addr = a;
    expect_out(nm, 0, e);
    drain();
  endtask

  task automatic redir(string nm, logic v, logic [31:0] pc, logic it);
    expect_out({nm, ".valid"}, 1, {31'd0, v});
    expect_out({nm, ".pc"}, 2, pc);
    expect_out({nm, ".int_taken"}, 3, {31'd0, it});
    drain();
  endtask

  task automatic ti_is(string nm, logic v);
    expect_out(nm, 4, {31'd0, v});
    drain();
  endtask

  task automatic mtc0(logic [4:0] a, logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    rd_addr = 5'd0;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    eret = 1'b0;
    int_pc = 32'd0;
    hw_int = 6'd0;
    // exception held during reset must not redirect
    exc_valid = 1'b1;
    exc_code = EXC_SYS;
    exc_pc = 32'h0040_0104;
    exc_bd = 1'b1;

    rv[0] = '{"rst_count",   REG_COUNT,   32'd0};
    rv[1] = '{"rst_compare", REG_COMPARE, 32'hFFFF_FFFF};
    rv[2] = '{"rst_status",  REG_STATUS,  32'h0040_0000};
    rv[3] = '{"rst_cause",   REG_CAUSE,   32'd0};
    rv[4] = '{"rst_epc",     REG_EPC,     VEC};
    rv[5] = '{"rst_unimpl",  5'd3,        32'd0};

    for (int i = 0; i < 6; i++) begin
      tick();
      redir("rst_redir", 1'b0, 32'd0, 1'b0);
      ti_is("rst_ti", 1'b0);
      rd(rv[i].nm, rv[i].addr, rv[i].exp);
    end

    tick();
    rst = 1'b0;
    exc_valid = 1'b0;
    exc_bd = 1'b0;

    // Timer interrupt: Compare = 5, Count restarted at 0, COUNT_DIV = 2
    mtc0(REG_STATUS, 32'h0000_8001);
    mtc0(REG_COMPARE, 32'd5);
    mtc0(REG_COUNT, 32'd0);
    int_pc = 32'h0040_0200;
    rd("cnt_start", REG_COUNT, 32'd0);
    rd("st_written", REG_STATUS, 32'h0000_8001);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) begin
        ti_is("ti_early", 1'b0);
        rd("cnt_9", REG_COUNT, 32'd4);
        redir("no_int_early", 1'b0, 32'd0, 1'b0);
      end else if (i == 10) begin
        ti_is("ti_rise", 1'b1);
        rd("cnt_10", REG_COUNT, 32'd5);
        redir("timer_int_take", 1'b1, VEC, 1'b1);
      end
    end
    tick();
    rd("int_status", REG_STATUS, 32'h0000_8003);
    rd("int_epc", REG_EPC, 32'h0040_0200);
    rd("int_cause", REG_CAUSE, 32'h4000_8000);
    redir("int_exl_blocks", 1'b0, 32'd0, 1'b0);
    mtc0(REG_COMPARE, 32'h0000_0100);
    rd("ti_clear_cause", REG_CAUSE, 32'd0);
    ti_is("ti_cleared", 1'b0);
    eret = 1'b1;
    redir("eret_int", 1'b1, 32'h0040_0200, 1'b0);
    tick();
    eret = 1'b0;
    rd("eret_int_status", REG_STATUS, 32'h0000_8001);

    // Syscall in a delay slot
    exc_valid = 1'b1;
    exc_code = EXC_SYS;
    exc_pc = 32'h0040_0104;
    exc_bd = 1'b1;
    redir("sys_redir", 1'b1, VEC, 1'b0);
    tick();
    exc_valid = 1'b0;
    exc_bd = 1'b0;
    rd("sys_epc", REG_EPC, 32'h0040_0100);
    rd("sys_cause", REG_CAUSE, 32'h8000_0020);
    rd("sys_status", REG_STATUS, 32'h0000_8003);
    eret = 1'b1;
    redir("sys_eret", 1'b1, 32'h0040_0100, 1'b0);
    tick();
    eret = 1'b0;
    rd("sys_eret_status", REG_STATUS, 32'h0000_8001);

    // Nested exception keeps EPC/BD, updates ExcCode
    exc_valid = 1'b1;
    exc_code = EXC_OV;
    exc_pc = 32'h0040_0300;
    tick();
    exc_code = EXC_RI;
    exc_pc = 32'h0000_1234;
    redir("nest_redir", 1'b1, VEC, 1'b0);
    tick();
    exc_valid = 1'b0;
    rd("nest_epc", REG_EPC, 32'h0040_0300);
    rd("nest_cause", REG_CAUSE, 32'h0000_0028);
    eret = 1'b1;
    redir("nest_eret", 1'b1, 32'h0040_0300, 1'b0);
    tick();
    eret = 1'b0;

    // Masked hardware interrupt, then unmasked
    hw_int = 6'b00_0001;
    int_pc = 32'h0040_0500;
    redir("hw_latency", 1'b0, 32'd0, 1'b0);
    tick();
    redir("hw_masked", 1'b0, 32'd0, 1'b0);
    rd("hw_ip2", REG_CAUSE, 32'h0000_0428);
    mtc0(REG_STATUS, 32'h0000_8401);
    redir("hw_unmasked", 1'b1, VEC, 1'b1);
    tick();
    rd("hw_epc", REG_EPC, 32'h0040_0500);
    rd("hw_cause", REG_CAUSE, 32'h0000_0400);
    rd("hw_status", REG_STATUS, 32'h0000_8403);

    // Exception + pending interrupt + eret + mtc0 Status in one cycle
    mtc0(REG_STATUS, 32'h0000_8401);
    exc_valid = 1'b1;
    exc_code = EXC_BP;
    exc_pc = 32'h0040_0600;
    eret = 1'b1;
    wr_en = 1'b1;
    wr_addr = REG_STATUS;
    wr_data = 32'h0000_0001;
    redir("all_redir", 1'b1, VEC, 1'b0);
    tick();
    exc_valid = 1'b0;
    eret = 1'b0;
    wr_en = 1'b0;
    rd("all_status", REG_STATUS, 32'h0000_8403);
    rd("all_epc", REG_EPC, 32'h0040_0600);
    rd("all_cause", REG_CAUSE, 32'h0000_0424);
    hw_int = 6'd0;

    // Count write on an increment cycle wins, then wraps after COUNT_DIV cycles
    mtc0(REG_COUNT, 32'd0);
    tick();
    mtc0(REG_COUNT, 32'hFFFF_FFFF);
    rd("cw_written", REG_COUNT, 32'hFFFF_FFFF);
    tick();
    rd("cw_hold", REG_COUNT, 32'hFFFF_FFFF);
    tick();
    rd("cw_wrap", REG_COUNT, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
